// File: rtl/crc20_frame_seq_if.sv
// Framed 32-bit word stream with sop/eop markers and a valid/ready handshake.
interface crc20_frame_seq_if;
    localparam int unsigned DW = 32;

    logic [DW-1:0] data;
    logic          valid;
    logic          sop;
    logic          eop;
    logic          ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/crc20_frame_seq.sv
// Frame sequencer for an external CRC-20 engine: clears and feeds the engine per frame,
// forwards payload words, appends a CRC trailer, and truncates over-length frames.
module crc20_frame_seq #(
    parameter logic [10:0] TRAILER_TAG = 11'h5A5,
    parameter logic [15:0] MAX_WORDS   = 16'd1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crc20_frame_seq_if.slave     s,
    crc20_frame_seq_if.master    m,
    output logic [31:0]          crc_data,
    output logic                 crc_en,
    output logic                 crc_clr,
    input  logic [19:0]          crc_res,
    output logic [15:0]          frame_cnt,
    output logic                 drop_pulse,
    output logic                 sop_err_pulse
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DW    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        DATA  = 3'd2,
        WAIT1 = 3'd3,
        WAIT2 = 3'd4,
        DROP  = 3'd5
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               len_err_q;
    logic [DW-1:0]      m_data_q;
    logic               m_valid_q;
    logic               m_sop_q;
    logic               m_eop_q;
    logic               crc_clr_q;
    logic               drop_q;
    logic               sop_err_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    logic               s_ready_c;
    logic               out_free_c;
    logic               hs_c;
    logic               last_word_c;

    assign out_free_c  = ~m_valid_q | m.ready;
    assign hs_c        = s.valid & s_ready_c;
    // Widened so MAX_WORDS = 65535 compares without wrapping.
    assign last_word_c = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_WORDS);

    always_comb begin
        s_ready_c = 1'b0;
        unique case (state_q)
            IDLE:    s_ready_c = s.valid & ~s.sop;
            DATA:    s_ready_c = out_free_c;
            DROP:    s_ready_c = 1'b1;
            default: s_ready_c = 1'b0;
        endcase
    end

    // Sequencer FSM together with the output register, pulses and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b0;
            crc_clr_q   <= 1'b1;
            drop_q      <= 1'b0;
            sop_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            crc_clr_q <= 1'b0;
            drop_q    <= 1'b0;
            sop_err_q <= 1'b0;

            if (m_valid_q && m.ready && m_eop_q) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            // Loads below override this drain in the same cycle.
            if (m.ready) begin
                m_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (s.valid) begin
                        if (s.sop) begin
                            state_q   <= CLR;
                            crc_clr_q <= 1'b1;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    cnt_q     <= '0;
                    len_err_q <= 1'b0;
                    state_q   <= DATA;
                end
                DATA: begin
                    if (hs_c) begin
                        m_data_q  <= s.data;
                        m_valid_q <= 1'b1;
                        m_sop_q   <= (cnt_q == '0);
                        m_eop_q   <= 1'b0;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (s.sop && (cnt_q != '0)) begin
                            sop_err_q <= 1'b1;
                        end
                        if (s.eop) begin
                            state_q <= WAIT1;
                        end else if (last_word_c) begin
                            len_err_q <= 1'b1;
                            state_q   <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    state_q <= WAIT2;
                end
                WAIT2: begin
                    if (out_free_c) begin
                        m_data_q  <= {TRAILER_TAG, len_err_q, crc_res};
                        m_valid_q <= 1'b1;
                        m_sop_q   <= 1'b0;
                        m_eop_q   <= 1'b1;
                        state_q   <= len_err_q ? DROP : IDLE;
                    end
                end
                DROP: begin
                    if (s.valid && s.eop) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s.ready       = s_ready_c;
    assign m.data        = m_data_q;
    assign m.valid       = m_valid_q;
    assign m.sop         = m_sop_q;
    assign m.eop         = m_eop_q;
    assign crc_data      = s.data;
    assign crc_en        = (state_q == DATA) & hs_c;
    assign crc_clr       = crc_clr_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_pulse    = drop_q;
    assign sop_err_pulse = sop_err_q;
endmodule

// File: tb/tb_crc20_frame_seq.sv
// Self-checking bench for crc20_frame_seq with a CRC-20 engine model and an output scoreboard.
module tb_crc20_frame_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    crc20_frame_seq_if s_if ();
    crc20_frame_seq_if m_if ();

    logic [31:0] crc_data;
    logic        crc_en;
    logic        crc_clr;
    logic [19:0] crc_res;
    logic [15:0] frame_cnt;
    logic        drop_pulse;
    logic        sop_err_pulse;

    crc20_frame_seq #(.TRAILER_TAG(11'h5A5), .MAX_WORDS(16'd4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s             (s_if),
        .m             (m_if),
        .crc_data      (crc_data),
        .crc_en        (crc_en),
        .crc_clr       (crc_clr),
        .crc_res       (crc_res),
        .frame_cnt     (frame_cnt),
        .drop_pulse    (drop_pulse),
        .sop_err_pulse (sop_err_pulse)
    );

    // MSB-first CRC-20, polynomial 0x1A4BCF.
    function automatic logic [19:0] crc_step(input logic [19:0] c, input logic [31:0] d);
        logic [19:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[19] ^ d[i];
            r  = {r[18:0], 1'b0};
            if (fb) r = r ^ 20'hA4BCF;
        end
        return r;
    endfunction

    // Engine: state register on crc_en, result register one edge later.
    logic [19:0] eng_q, eng_res_q;
    bit          stub = 1'b1;
    always @(posedge clk) begin
        if (crc_clr) begin
            eng_q     <= 20'hFFFFF;
            eng_res_q <= 20'hFFFFF;
        end else begin
            if (crc_en) eng_q <= crc_step(eng_q, crc_data);
            eng_res_q <= eng_q;
        end
    end
    assign crc_res = stub ? 20'hABCDE : eng_res_q;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int en_cnt = 0, clr_cnt = 0, drop_cnt = 0, sop_err_cnt = 0;
    int frames = 0;

    function automatic beat_t mk(input logic [31:0] d, input logic sop, input logic eop);
        beat_t b;
        b.data = d; b.sop = sop; b.eop = eop;
        return b;
    endfunction

    task automatic monitor();
        beat_t e, got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (crc_en)        en_cnt++;
                if (crc_clr)       clr_cnt++;
                if (drop_pulse)    drop_cnt++;
                if (sop_err_pulse) sop_err_cnt++;
                if (m_if.valid && m_if.ready) begin
                    got = {m_if.data, m_if.sop, m_if.eop};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got data=%h sop=%b eop=%b, required no output",
                                 got.data, got.sop, got.eop);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL sb_beat: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                                     got.data, got.sop, got.eop, e.data, e.sop, e.eop);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic sop, input logic eop);
        bit hs;
        int n;
        s_if.data = d; s_if.sop = sop; s_if.eop = eop; s_if.valid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_if.ready;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles, required acceptance", d, n);
        end
        s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_frames(input string tag);
        checks++;
        if (frame_cnt !== 16'(frames)) begin
            errors++;
            $display("FAIL frame_cnt_%s: got %0d, required %0d", tag, frame_cnt, frames);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b, required 0", m_if.valid); end
        checks++; if ({m_if.sop, m_if.eop} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop: got %b, required 00", {m_if.sop, m_if.eop}); end
        checks++; if (m_if.data !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %h, required 0", m_if.data); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
        checks++; if (crc_clr !== 1'b1) begin errors++; $display("FAIL rst_crc_clr: got %b, required 1", crc_clr); end
        checks++; if ({drop_pulse, sop_err_pulse} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b, required 00", {drop_pulse, sop_err_pulse}); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (crc_clr !== 1'b0) begin errors++; $display("FAIL rst_clr_fall: got %b, required 0", crc_clr); end
    endtask

    task automatic test_single_stub();
        int c0;
        stub = 1'b1;
        c0 = clr_cnt;
        exp_q.push_back(mk(32'h12345678, 1'b1, 1'b0));
        exp_q.push_back(mk(32'hB4AABCDE, 1'b0, 1'b1));
        frames++;
        send(32'h12345678, 1'b1, 1'b1);
        checks++;
        if ({m_if.valid, m_if.sop, m_if.data} !== {1'b1, 1'b1, 32'h12345678}) begin
            errors++; $display("FAIL single_word: got v=%b sop=%b data=%h, required v=1 sop=1 data=12345678", m_if.valid, m_if.sop, m_if.data);
        end
        checks++;
        if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL single_clr_pulses: got %0d, required 1", clr_cnt - c0); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_if.valid, m_if.eop, m_if.data} !== {1'b1, 1'b1, 32'hB4AABCDE}) begin
            errors++; $display("FAIL single_trailer_time: got v=%b eop=%b data=%h, required v=1 eop=1 data=b4aabcde", m_if.valid, m_if.eop, m_if.data);
        end
        drain();
        check_frames("single");
    endtask

    task automatic test_real_crc();
        logic [19:0] c;
        int e0;
        stub = 1'b0;
        e0 = en_cnt;
        c = 20'hFFFFF;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(32'(i), i == 0, 1'b0));
            c = crc_step(c, 32'(i));
        end
        exp_q.push_back(mk({11'h5A5, 1'b0, c}, 1'b0, 1'b1));
        frames++;
        for (int i = 0; i < 4; i++) send(32'(i), i == 0, i == 3);
        drain();
        checks++;
        if (en_cnt - e0 !== 4) begin errors++; $display("FAIL real_crc_en: got %0d pulses, required 4", en_cnt - e0); end
        check_frames("real");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[4];
        logic [19:0] c;
        int e0, c0;
        stub = 1'b0;
        e0 = en_cnt; c0 = clr_cnt;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int f = 0; f < 2; f++) begin
            c = crc_step(crc_step(20'hFFFFF, w[2*f]), w[2*f+1]);
            exp_q.push_back(mk(w[2*f], 1'b1, 1'b0));
            exp_q.push_back(mk(w[2*f+1], 1'b0, 1'b0));
            exp_q.push_back(mk({11'h5A5, 1'b0, c}, 1'b0, 1'b1));
            frames++;
        end
        for (int i = 0; i < 4; i++) send(w[i], (i % 2) == 0, (i % 2) == 1);
        drain();
        checks++;
        if (en_cnt - e0 !== 4) begin errors++; $display("FAIL b2b_crc_en: got %0d, required 4", en_cnt - e0); end
        checks++;
        if (clr_cnt - c0 !== 2) begin errors++; $display("FAIL b2b_clr: got %0d, required 2", clr_cnt - c0); end
        check_frames("b2b");
    endtask

    task automatic test_backpressure();
        logic [19:0] c;
        stub = 1'b0;
        c = 20'hFFFFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'hA000_0000 + 32'(i), i == 0, 1'b0));
            c = crc_step(c, 32'hA000_0000 + 32'(i));
        end
        exp_q.push_back(mk({11'h5A5, 1'b0, c}, 1'b0, 1'b1));
        frames++;
        fork
            begin
                for (int i = 0; i < 3; i++) send(32'hA000_0000 + 32'(i), i == 0, i == 2);
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); #1;
                    m_if.ready = ~m_if.ready;
                end
            end
        join
        m_if.ready = 1'b1;
        drain();
        check_frames("bp");
    endtask

    task automatic test_truncation();
        int e0, d0;
        stub = 1'b1;
        e0 = en_cnt; d0 = drop_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'hC000_0000 + 32'(i), i == 0, 1'b0));
        exp_q.push_back(mk(32'hB4BABCDE, 1'b0, 1'b1));
        frames++;
        for (int i = 0; i < 6; i++) send(32'hC000_0000 + 32'(i), i == 0, i == 5);
        drain();
        checks++;
        if (en_cnt - e0 !== 4) begin errors++; $display("FAIL trunc_crc_en: got %0d, required 4", en_cnt - e0); end
        checks++;
        if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL trunc_drop: got %0d, required 0", drop_cnt - d0); end
        check_frames("trunc");
    endtask

    task automatic test_protocol();
        logic [19:0] c;
        int s0;
        send(32'hDEAD0001, 1'b0, 1'b0);
        checks++;
        if (drop_pulse !== 1'b1) begin errors++; $display("FAIL proto_drop_hi: got %b, required 1", drop_pulse); end
        checks++;
        if (m_if.valid !== 1'b0) begin errors++; $display("FAIL proto_drop_out: got m_valid=%b, required 0", m_if.valid); end
        @(posedge clk); #1;
        checks++;
        if (drop_pulse !== 1'b0) begin errors++; $display("FAIL proto_drop_lo: got %b, required 0", drop_pulse); end
        stub = 1'b0;
        s0 = sop_err_cnt;
        c = 20'hFFFFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'hE000_0000 + 32'(i), i == 0, 1'b0));
            c = crc_step(c, 32'hE000_0000 + 32'(i));
        end
        exp_q.push_back(mk({11'h5A5, 1'b0, c}, 1'b0, 1'b1));
        frames++;
        for (int i = 0; i < 3; i++) send(32'hE000_0000 + 32'(i), i < 2, i == 2);
        drain();
        checks++;
        if (sop_err_cnt - s0 !== 1) begin errors++; $display("FAIL proto_sop_err: got %0d, required 1", sop_err_cnt - s0); end
        check_frames("proto");
    endtask

    task automatic test_reset_mid();
        logic [19:0] c;
        stub = 1'b0;
        exp_q.push_back(mk(32'hF000_0000, 1'b1, 1'b0));
        send(32'hF000_0000, 1'b1, 1'b0);
        send(32'hF000_0001, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", m_if.valid); end
        checks++; if (crc_clr !== 1'b1) begin errors++; $display("FAIL mid_rst_clr: got %b, required 1", crc_clr); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_frame_cnt: got %0d, required 0", frame_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_rst_sb: %0d beats outstanding, required 0", exp_q.size()); end
        frames = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        c = 20'hFFFFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'h1234_0000 + 32'(i), i == 0, 1'b0));
            c = crc_step(c, 32'h1234_0000 + 32'(i));
        end
        exp_q.push_back(mk({11'h5A5, 1'b0, c}, 1'b0, 1'b1));
        frames++;
        for (int i = 0; i < 3; i++) send(32'h1234_0000 + 32'(i), i == 0, i == 2);
        drain();
        check_frames("after_rst");
    endtask

    initial begin
        s_if.data = '0; s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0;
        m_if.ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_single_stub();
        test_real_crc();
        test_back_to_back();
        test_backpressure();
        test_truncation();
        test_protocol();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
